// File: rtl/clkgen_pkg.sv
// Shared defaults and slice-indexing helpers for the multi-channel strobe/square generator.
package clkgen_pkg;

   localparam int unsigned N_DEF   = 16;
   localparam int unsigned NCH_DEF = 4;

   // Low bit of channel k inside a packed bus of w-bit fields.
   function automatic int unsigned chan_lo(input int unsigned k, input int unsigned w);
      return k * w;
   endfunction

   function automatic int unsigned bus_w(input int unsigned nch, input int unsigned w);
      return nch * w;
   endfunction

endpackage

// File: rtl/clkgen_chan.sv
// One divider channel: programmable period, one-cycle strobe, square wave toggling per strobe,
// with immediate or wrap-deferred period reload and a phase-reset input.
module clkgen_chan
   import clkgen_pkg::*;
#(
   parameter int unsigned    N          = N_DEF,
   parameter logic [N-1:0]   PERIOD_RST = '0
) (
   input  logic         clk_i,
   input  logic         reset,
   input  logic [N-1:0] maxval_i,
   input  logic         load_i,
   input  logic         immediate_i,
   input  logic         enable_i,
   input  logic         sync_i,
   output logic         strobe_o,
   output logic         square_o,
   output logic         pending_o
);

   logic [N-1:0] ctr_q, ctr_d;
   logic [N-1:0] per_act_q, per_act_d;
   logic [N-1:0] per_shadow_q, per_shadow_d;
   logic         pending_q, pending_d;
   logic         strobe_q, strobe_d;
   logic         square_q, square_d;
   logic         wrap;

   // Compare against the old period; >= keeps a lowered period from running past it.
   assign wrap = enable_i && (ctr_q >= per_act_q);

   always_comb begin
      ctr_d        = ctr_q;
      per_act_d    = per_act_q;
      per_shadow_d = per_shadow_q;
      pending_d    = pending_q;
      strobe_d     = 1'b0;
      square_d     = square_q;

      if (sync_i) begin
         ctr_d    = '0;
         square_d = 1'b0;
         if (load_i) begin
            per_act_d = maxval_i;
            pending_d = 1'b0;
         end
      end else if (load_i && immediate_i) begin
         per_act_d = maxval_i;
         ctr_d     = '0;
         pending_d = 1'b0;
      end else if (wrap) begin
         ctr_d    = '0;
         strobe_d = 1'b1;
         square_d = ~square_q;
         // A deferred load landing on the wrap bypasses the shadow entirely.
         if (load_i) begin
            per_act_d = maxval_i;
            pending_d = 1'b0;
         end else if (pending_q) begin
            per_act_d = per_shadow_q;
            pending_d = 1'b0;
         end
      end else begin
         if (enable_i) begin
            ctr_d = ctr_q + N'(1);
         end
         if (load_i) begin
            per_shadow_d = maxval_i;
            pending_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         ctr_q        <= '0;
         per_act_q    <= PERIOD_RST;
         per_shadow_q <= PERIOD_RST;
         pending_q    <= 1'b0;
         strobe_q     <= 1'b0;
         square_q     <= 1'b0;
      end else begin
         ctr_q        <= ctr_d;
         per_act_q    <= per_act_d;
         per_shadow_q <= per_shadow_d;
         pending_q    <= pending_d;
         strobe_q     <= strobe_d;
         square_q     <= square_d;
      end
   end

   assign strobe_o  = strobe_q;
   assign square_o  = square_q;
   assign pending_o = pending_q;

endmodule

// File: rtl/clkgen_multi.sv
// NCH independent divider channels sharing sync and immediate-load controls.
module clkgen_multi
   import clkgen_pkg::*;
#(
   parameter int unsigned  N          = N_DEF,
   parameter int unsigned  NCH        = NCH_DEF,
   parameter logic [N-1:0] PERIOD_RST = '0
) (
   input  logic                          clk_i,
   input  logic                          reset,
   input  logic [bus_w(NCH, N)-1:0]      maxval_i,
   input  logic [NCH-1:0]                load_i,
   input  logic                          immediate_i,
   input  logic [NCH-1:0]                enable_i,
   input  logic                          sync_i,
   output logic [NCH-1:0]                strobe_o,
   output logic [NCH-1:0]                square_o,
   output logic [NCH-1:0]                pending_o
);

   for (genvar k = 0; k < NCH; k++) begin : g_chan
      clkgen_chan #(
         .N          (N),
         .PERIOD_RST (PERIOD_RST)
      ) u_chan (
         .clk_i       (clk_i),
         .reset       (reset),
         .maxval_i    (maxval_i[chan_lo(k, N) +: N]),
         .load_i      (load_i[k]),
         .immediate_i (immediate_i),
         .enable_i    (enable_i[k]),
         .sync_i      (sync_i),
         .strobe_o    (strobe_o[k]),
         .square_o    (square_o[k]),
         .pending_o   (pending_o[k])
      );
   end

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed plus randomized check of clkgen_multi against a cycle-level behavioural model.
module tb_clkgen_multi;

   localparam int unsigned N   = 8;
   localparam int unsigned NCH = 4;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [NCH*N-1:0]   maxval_i = '0;
   logic [NCH-1:0]     load_i = '0;
   logic               immediate_i = 1'b0;
   logic [NCH-1:0]     enable_i = '0;
   logic               sync_i = 1'b0;
   logic [NCH-1:0]     strobe_o, square_o, pending_o;

   clkgen_multi #(
      .N          (N),
      .NCH        (NCH),
      .PERIOD_RST (8'd0)
   ) dut (
      .clk_i       (clk),
      .reset       (reset),
      .maxval_i    (maxval_i),
      .load_i      (load_i),
      .immediate_i (immediate_i),
      .enable_i    (enable_i),
      .sync_i      (sync_i),
      .strobe_o    (strobe_o),
      .square_o    (square_o),
      .pending_o   (pending_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Model state: counter position, active/shadow period, flags.
   int m_ctr [NCH];
   int m_act [NCH];
   int m_shd [NCH];
   bit m_pend[NCH];
   bit m_str [NCH];
   bit m_sq  [NCH];
   int last_str[NCH];
   int last_gap[NCH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < NCH; k++) begin
         m_ctr[k] = 0; m_act[k] = 0; m_shd[k] = 0;
         m_pend[k] = 0; m_str[k] = 0; m_sq[k] = 0;
      end
   endfunction

   function automatic void model_step();
      int mv;
      if (reset) begin
         model_reset();
         return;
      end
      for (int k = 0; k < NCH; k++) begin
         mv = int'(maxval_i[k*N +: N]);
         m_str[k] = 0;
         if (sync_i) begin
            m_ctr[k] = 0;
            m_sq[k]  = 0;
            if (load_i[k]) begin m_act[k] = mv; m_pend[k] = 0; end
         end else if (load_i[k] && immediate_i) begin
            m_act[k] = mv; m_ctr[k] = 0; m_pend[k] = 0;
         end else if (enable_i[k] && m_ctr[k] >= m_act[k]) begin
            m_ctr[k] = 0;
            m_str[k] = 1;
            m_sq[k]  = !m_sq[k];
            if (load_i[k]) begin m_act[k] = mv; m_pend[k] = 0; end
            else if (m_pend[k]) begin m_act[k] = m_shd[k]; m_pend[k] = 0; end
         end else begin
            if (enable_i[k]) m_ctr[k] = m_ctr[k] + 1;
            if (load_i[k]) begin m_shd[k] = mv; m_pend[k] = 1; end
         end
      end
   endfunction

   task automatic cycle();
      logic [NCH-1:0] es, eq, ep;
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      for (int k = 0; k < NCH; k++) begin
         es[k] = m_str[k]; eq[k] = m_sq[k]; ep[k] = m_pend[k];
      end
      chk("strobe", 32'(strobe_o), 32'(es));
      chk("square", 32'(square_o), 32'(eq));
      chk("pending", 32'(pending_o), 32'(ep));
      for (int k = 0; k < NCH; k++) begin
         if (strobe_o[k] === 1'b1) begin
            last_gap[k] = cyc - last_str[k];
            last_str[k] = cyc;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic set_mv(input int k, input int v);
      maxval_i[k*N +: N] = N'(v);
   endtask

   task automatic imm_load(input int k, input int v);
      set_mv(k, v);
      load_i[k] = 1'b1; immediate_i = 1'b1;
      cycle();
      load_i[k] = 1'b0; immediate_i = 1'b0;
   endtask

   task automatic def_load(input int k, input int v);
      set_mv(k, v);
      load_i[k] = 1'b1; immediate_i = 1'b0;
      cycle();
      load_i[k] = 1'b0;
   endtask

   task automatic wait_ctr(input int k, input int v, input string tag);
      bit hit = 0;
      for (int i = 0; i < 600 && !hit; i++) begin
         if (m_ctr[k] == v) hit = 1;
         else cycle();
      end
      chk(tag, 32'(hit), 32'd1);
   endtask

   task automatic wait_strobe(input int k, input string tag);
      bit hit = 0;
      for (int i = 0; i < 600 && !hit; i++) begin
         cycle();
         if (strobe_o[k] === 1'b1) hit = 1;
      end
      chk(tag, 32'(hit), 32'd1);
   endtask

   initial begin
      model_reset();
      for (int k = 0; k < NCH; k++) begin last_str[k] = 0; last_gap[k] = 0; end

      // Reset state
      run(2);
      chk("rst_strobe", 32'(strobe_o), 32'd0);
      chk("rst_square", 32'(square_o), 32'd0);
      chk("rst_pending", 32'(pending_o), 32'd0);

      // ch0 at PERIOD_RST=0: strobe every cycle, square 1,0,1
      reset = 1'b0;
      enable_i[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("ch0_p0_strobe", 32'(strobe_o[0]), 32'd1);
         chk("ch0_p0_square", 32'(square_o[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      end

      // ch1 immediate load 4 -> strobe every 5 cycles
      enable_i[1] = 1'b1;
      imm_load(1, 4);
      run(22);
      chk("ch1_gap5", 32'(last_gap[1]), 32'd5);
      chk("ch1_nopend", 32'(pending_o[1]), 32'd0);

      // ch2 period 9, deferred load of 2 at ctr=3
      enable_i[2] = 1'b1;
      imm_load(2, 9);
      run(12);
      wait_ctr(2, 3, "ch2_reach_ctr3");
      def_load(2, 2);
      chk("ch2_pending_set", 32'(pending_o[2]), 32'd1);
      wait_strobe(2, "ch2_old_wrap");
      chk("ch2_old_gap", 32'(last_gap[2]), 32'd10);
      chk("ch2_pending_clr", 32'(pending_o[2]), 32'd0);
      wait_strobe(2, "ch2_new_wrap");
      chk("ch2_new_gap", 32'(last_gap[2]), 32'd3);

      // ch3: deferred load on the wrap cycle, then two loads before a wrap
      enable_i[3] = 1'b1;
      imm_load(3, 5);
      wait_ctr(3, 5, "ch3_reach_wrap");
      def_load(3, 3);
      chk("ch3_wrap_strobe", 32'(strobe_o[3]), 32'd1);
      chk("ch3_wrap_nopend", 32'(pending_o[3]), 32'd0);
      wait_strobe(3, "ch3_after_wrap");
      chk("ch3_gap4", 32'(last_gap[3]), 32'd4);
      def_load(3, 7);
      def_load(3, 3);
      wait_strobe(3, "ch3_wrap_a");
      wait_strobe(3, "ch3_wrap_b");
      chk("ch3_last_wins", 32'(last_gap[3]), 32'd4);

      // ch0 period 6, frozen 5 cycles mid-period
      imm_load(0, 6);
      run(10);
      wait_ctr(0, 2, "ch0_reach_ctr2");
      enable_i[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("ch0_frozen_strobe", 32'(strobe_o[0]), 32'd0);
      end
      enable_i[0] = 1'b1;
      wait_strobe(0, "ch0_resume");
      chk("ch0_frozen_gap", 32'(last_gap[0]), 32'd12);

      // Global sync with ch1/ch3 reloaded to equal periods
      run(3);
      set_mv(1, 5); set_mv(3, 5);
      load_i = 4'b1010; sync_i = 1'b1;
      cycle();
      load_i = '0; sync_i = 1'b0;
      chk("sync_square", 32'(square_o), 32'd0);
      chk("sync_strobe", 32'(strobe_o), 32'd0);
      for (int i = 0; i < 14; i++) begin
         cycle();
         chk("sync_equal_phase", 32'(strobe_o[1]), 32'(strobe_o[3]));
      end

      // Maximum period: 2^N cycles between strobes
      imm_load(1, 255);
      wait_strobe(1, "ch1_max_a");
      wait_strobe(1, "ch1_max_b");
      chk("ch1_max_gap", 32'(last_gap[1]), 32'd256);

      // Reset mid-period with a load pending
      imm_load(2, 20);
      run(2);
      def_load(2, 7);
      chk("rst_mid_pending", 32'(pending_o[2]), 32'd1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("rst_mid_strobe", 32'(strobe_o), 32'd0);
      chk("rst_mid_square", 32'(square_o), 32'd0);
      chk("rst_mid_pending0", 32'(pending_o), 32'd0);
      enable_i = '1;
      run(3);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset       = ($urandom_range(0, 199) == 0);
         sync_i      = ($urandom_range(0, 99) == 0);
         immediate_i = 1'($urandom_range(0, 1));
         for (int k = 0; k < NCH; k++) begin
            load_i[k]   = ($urandom_range(0, 15) == 0);
            enable_i[k] = ($urandom_range(0, 7) != 0);
            set_mv(k, ($urandom_range(0, 31) == 0) ? 255 : $urandom_range(0, 12));
         end
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
